axi_mem_responder: RTL and testbench

// - AXI4 subordinate (responder) backed by on-chip word RAM; the memory end of the instruction/data AXI ports driven by the pipeline cache.
// - Serves single-beat data reads/writes and 16-beat INCR instruction line fills.
// - Used as the simulation/FPGA main-memory model behind both AXI master ports.

---
 rtl/axi_mem_pkg.sv | 39 +++
 rtl/axi_mem_ram.sv | 42 ++++
 rtl/axi_mem_responder.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_pkg.sv
// Package shared by the AXI memory responder and its RAM.
// Contents: response and burst encodings, the write and read FSM state
// enums, the word transfer size, and the command legality helper.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01
    } burst_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } r_state_t;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    // A command is illegal for non-word size, WRAP/reserved burst, or an
    // over-long burst. Address range is judged per beat elsewhere.
    function automatic logic cmd_bad(input logic [2:0] size,
                                     input logic [1:0] burst,
                                     input logic [7:0] len,
                                     input logic [7:0] max_len);
        return (size != SIZE_WORD) || (burst[1] != 1'b0) || (len > max_len);
    endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Word RAM with a byte-enable write port and a registered read port.
// Ports:
//   clk       clock
//   we_i      write enable; wstrb_i selects bytes of wdata_i at waddr_i
//   re_i      read enable; rdata_o updates with mem[raddr_i] one edge later
//             and holds while re_i is low
// Contents are not reset. A read and write of the same word on the same
// edge returns the old word.
module axi_mem_ram
    import axi_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 16384,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    wstrb_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-masked write and registered read (read-first by NBA ordering).
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i && wstrb_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by on-chip word RAM: single-beat data accesses and
// INCR/FIXED bursts up to MAX_LEN+1 beats, one outstanding transaction per
// channel, independent read and write FSMs.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   mem_aw* / mem_w* / mem_b*           write address, data, response
//   mem_ar* / mem_r*                    read address, data/response/last
// Optional feature macro AXI_MEM_STALL_EN: a 16-bit LFSR (seed 16'hACE1)
// randomly withholds awready/wready/arready and delays the start of each
// read beat; a raised valid is never withdrawn.
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MAX_LEN     = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_awvalid,
    output logic        mem_awready,
    input  logic [31:0] mem_awaddr,
    input  logic [7:0]  mem_awlen,
    input  logic [2:0]  mem_awsize,
    input  logic [1:0]  mem_awburst,
    input  logic        mem_wvalid,
    output logic        mem_wready,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    input  logic        mem_wlast,
    output logic        mem_bvalid,
    input  logic        mem_bready,
    output logic [1:0]  mem_bresp,
    input  logic        mem_arvalid,
    output logic        mem_arready,
    input  logic [31:0] mem_araddr,
    input  logic [7:0]  mem_arlen,
    input  logic [2:0]  mem_arsize,
    input  logic [1:0]  mem_arburst,
    output logic        mem_rvalid,
    input  logic        mem_rready,
    output logic [31:0] mem_rdata,
    output logic [1:0]  mem_rresp,
    output logic        mem_rlast
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    // Byte address inside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).
    function automatic logic in_range(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return (a >= BASE_ADDR) && (off < (33'(DEPTH_WORDS) * 33'd4));
    endfunction

    // Word index; the low address bits are ignored and the index wraps.
    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return AW'(off >> 2);
    endfunction

    logic go_s;
`ifdef AXI_MEM_STALL_EN
    logic [15:0] lfsr_q;

    // Free-running Fibonacci LFSR; bit0 low means "stall this cycle".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end
    assign go_s = lfsr_q[0];
`else
    assign go_s = 1'b1;
`endif

    // ---------------- write channel ----------------
    w_state_t    w_state_q;
    logic [31:0] w_addr_q, w_addr_d;
    logic [7:0]  w_len_q, w_beat_q;
    logic        w_incr_q, w_cmd_err_q, w_err_q;
    logic        awready_q, wready_q, bvalid_q;
    resp_t       bresp_q;
    logic        aw_hs_s, w_hs_s, w_beat_err_s, w_cnt_last_s, w_exit_s, w_err_acc_s;
    logic        ram_we_s;

    assign mem_awready  = awready_q & go_s;
    assign mem_wready   = wready_q & go_s;
    assign aw_hs_s      = mem_awvalid & mem_awready;
    assign w_hs_s       = mem_wvalid & mem_wready;
    assign w_beat_err_s = w_cmd_err_q | ~in_range(w_addr_q);
    assign w_cnt_last_s = (w_beat_q == w_len_q);
    assign w_exit_s     = w_cnt_last_s | mem_wlast;
    // wlast disagreeing with the beat count (early or late) is an error.
    assign w_err_acc_s  = w_err_q | w_beat_err_s | (mem_wlast ^ w_cnt_last_s);
    assign w_addr_d     = w_incr_q ? (w_addr_q + 32'd4) : w_addr_q;
    assign ram_we_s     = (w_state_q == W_DATA) & w_hs_s & ~w_beat_err_s;

    // Write FSM: address capture, data beats, response hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q   <= W_IDLE;
            w_addr_q    <= 32'h0;
            w_len_q     <= 8'h0;
            w_beat_q    <= 8'h0;
            w_incr_q    <= 1'b0;
            w_cmd_err_q <= 1'b0;
            w_err_q     <= 1'b0;
            awready_q   <= 1'b1;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs_s) begin
                        w_addr_q    <= mem_awaddr;
                        w_len_q     <= mem_awlen;
                        w_beat_q    <= 8'h0;
                        w_incr_q    <= (mem_awburst == INCR);
                        w_cmd_err_q <= cmd_bad(mem_awsize, mem_awburst, mem_awlen, MAX_LEN_B);
                        w_err_q     <= 1'b0;
                        awready_q   <= 1'b0;
                        wready_q    <= 1'b1;
                        w_state_q   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        if (w_exit_s) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= w_err_acc_s ? SLVERR : OKAY;
                            w_state_q <= W_RESP;
                        end else begin
                            w_beat_q <= w_beat_q + 8'd1;
                            w_addr_q <= w_addr_d;
                            w_err_q  <= w_err_acc_s;
                        end
                    end
                end
                W_RESP: begin
                    if (mem_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                    awready_q <= 1'b1;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_bvalid = bvalid_q;
    assign mem_bresp  = bresp_q;

    // ---------------- read channel ----------------
    r_state_t    r_state_q;
    logic [31:0] r_addr_q, r_addr_d;
    logic [7:0]  r_len_q, r_beat_q;
    logic        r_incr_q, r_cmd_err_q;
    logic        arready_q, rvalid_q, rlast_q;
    resp_t       rresp_q;
    logic [31:0] rdata_q;
    logic        ar_hs_s, r_hs_s, r_beat_err_s;
    logic        ram_re_s;
    logic [AW-1:0] ram_raddr_s;
    logic [31:0] ram_rdata_s;

    assign mem_arready  = arready_q & go_s;
    assign ar_hs_s      = mem_arvalid & mem_arready;
    assign r_hs_s       = rvalid_q & mem_rready;
    assign r_beat_err_s = r_cmd_err_q | ~in_range(r_addr_q);
    assign r_addr_d     = r_incr_q ? (r_addr_q + 32'd4) : r_addr_q;

    // RAM read launch: first beat on AR handshake, later beats on R handshake.
    always_comb begin
        ram_re_s    = 1'b0;
        ram_raddr_s = word_idx(r_addr_d);
        if (ar_hs_s) begin
            ram_re_s    = 1'b1;
            ram_raddr_s = word_idx(mem_araddr);
        end else if (r_hs_s && !rlast_q) begin
            ram_re_s    = 1'b1;
            ram_raddr_s = word_idx(r_addr_d);
        end else begin
            ram_re_s = 1'b0;
        end
    end

    // Read FSM: the RAM output holds while no read is launched, so R_FETCH
    // may linger (stall) without losing the fetched word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q   <= R_IDLE;
            r_addr_q    <= 32'h0;
            r_len_q     <= 8'h0;
            r_beat_q    <= 8'h0;
            r_incr_q    <= 1'b0;
            r_cmd_err_q <= 1'b0;
            arready_q   <= 1'b1;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rresp_q     <= OKAY;
            rdata_q     <= 32'h0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        r_addr_q    <= mem_araddr;
                        r_len_q     <= mem_arlen;
                        r_beat_q    <= 8'h0;
                        r_incr_q    <= (mem_arburst == INCR);
                        r_cmd_err_q <= cmd_bad(mem_arsize, mem_arburst, mem_arlen, MAX_LEN_B);
                        arready_q   <= 1'b0;
                        r_state_q   <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    if (go_s) begin
                        rvalid_q  <= 1'b1;
                        rdata_q   <= r_beat_err_s ? 32'h0 : ram_rdata_s;
                        rresp_q   <= r_beat_err_s ? SLVERR : OKAY;
                        rlast_q   <= (r_beat_q == r_len_q);
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (mem_rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_addr_q  <= r_addr_d;
                            r_beat_q  <= r_beat_q + 8'd1;
                            r_state_q <= R_FETCH;
                        end
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                    rlast_q   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rvalid = rvalid_q;
    assign mem_rdata  = rdata_q;
    assign mem_rresp  = rresp_q;
    assign mem_rlast  = rlast_q;

    axi_mem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk    (clk),
        .we_i   (ram_we_s),
        .wstrb_i(mem_wstrb),
        .waddr_i(word_idx(w_addr_q)),
        .wdata_i(mem_wdata),
        .re_i   (ram_re_s),
        .raddr_i(ram_raddr_s),
        .rdata_o(ram_rdata_s)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
module tb_axi_mem_responder;

    localparam int          DEPTH = 16384;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk, rst_n;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        arvalid, arready, rvalid, rready, rlast;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] wd_a [16];
    logic [3:0]  ws_a [16];

    axi_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .MAX_LEN(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_awvalid(awvalid), .mem_awready(awready), .mem_awaddr(awaddr),
        .mem_awlen(awlen), .mem_awsize(awsize), .mem_awburst(awburst),
        .mem_wvalid(wvalid), .mem_wready(wready), .mem_wdata(wdata),
        .mem_wstrb(wstrb), .mem_wlast(wlast),
        .mem_bvalid(bvalid), .mem_bready(bready), .mem_bresp(bresp),
        .mem_arvalid(arvalid), .mem_arready(arready), .mem_araddr(araddr),
        .mem_arlen(arlen), .mem_arsize(arsize), .mem_arburst(arburst),
        .mem_rvalid(rvalid), .mem_rready(rready), .mem_rdata(rdata),
        .mem_rresp(rresp), .mem_rlast(rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_in_range(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && ((longint'(a) - longint'(BASE)) < 64'(4 * DEPTH));
    endfunction

    function automatic bit m_bad(input logic [2:0] size, input logic [1:0] burst, input int len);
        return (size != 3'b010) || (burst == 2'b10) || (burst == 2'b11) || (len > 15);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off >> 2) & 32'(DEPTH - 1));
    endfunction

    // Writes wd_a/ws_a beats; wlast asserted on beat wlast_at (stops sending there).
    task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input int wlast_at, input string tag);
        int nb, beat, t, tw;
        bit bad, exp_err, hs_aw, hs_w;
        logic [31:0] ba;
        nb      = ((wlast_at < len) ? wlast_at : len) + 1;
        bad     = m_bad(size, burst, len);
        exp_err = bad || (wlast_at != len);
        for (int i = 0; i < nb; i++) begin
            ba = (burst == 2'b00) ? addr : addr + 32'(4 * i);
            if (!m_in_range(ba)) exp_err = 1'b1;
            else if (!bad) begin
                for (int b = 0; b < 4; b++)
                    if (ws_a[i][b]) model[m_idx(ba)][8*b +: 8] = wd_a[i][8*b +: 8];
            end
        end
        beat = 0; t = 0; tw = -100;
        @(negedge clk);
        awvalid = 1'b1; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst;
        wvalid = 1'b1; wdata = wd_a[0]; wstrb = ws_a[0]; wlast = (wlast_at == 0);
        while (beat < nb && t < 400) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            if (hs_w) tw = t;
            @(negedge clk); t++;
            if (hs_aw) awvalid = 1'b0;
            if (hs_w) begin
                beat++;
                if (beat < nb) begin
                    wdata = wd_a[beat]; wstrb = ws_a[beat]; wlast = (beat == wlast_at);
                end else begin
                    wvalid = 1'b0; wlast = 1'b0;
                end
            end
        end
        while (!bvalid && t < 400) begin
            @(negedge clk); t++;
        end
        chk({tag, "_btimeout"}, 32'(t >= 400), 32'd0);
`ifndef AXI_MEM_STALL_EN
        chk({tag, "_blatency"}, 32'(t - tw), 32'd1);
`endif
        chk({tag, "_bresp"}, 32'(bresp), exp_err ? 32'd2 : 32'd0);
        @(negedge clk);
        chk({tag, "_bdrop"}, 32'(bvalid), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input bit toggle, input int abort_at,
                           input string tag);
        int t, tar, first_rv, beat;
        bit hs_ar, stalled, aborted, bad;
        logic [31:0] pd, ba, ed;
        logic pl;
        logic [1:0] pr;
        t = 0; tar = -1; first_rv = -1; beat = 0; stalled = 0; aborted = 0;
        pd = 32'h0; pl = 1'b0; pr = 2'b00;
        @(negedge clk);
        araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
        rready = toggle ? 1'b0 : 1'b1;
        while (beat <= len && t < 2000 && !aborted) begin
            hs_ar = arvalid && arready;
            if (hs_ar) tar = t;
            if (stalled) begin
                chk($sformatf("%s_b%0d_vhold", tag, beat), 32'(rvalid), 32'd1);
                chk($sformatf("%s_b%0d_dhold", tag, beat), rdata, pd);
                chk($sformatf("%s_b%0d_lhold", tag, beat), 32'(rlast), 32'(pl));
                chk($sformatf("%s_b%0d_rhold", tag, beat), 32'(rresp), 32'(pr));
            end
            stalled = 1'b0;
            if (rvalid && abort_at == beat) begin
                #2 rst_n = 1'b0;
                #1;
                chk({tag, "_rst_rvalid"}, 32'(rvalid), 32'd0);
                chk({tag, "_rst_arready"}, 32'(arready), 32'd1);
                chk({tag, "_rst_rdata"}, rdata, 32'd0);
                aborted = 1'b1;
                arvalid = 1'b0;
            end else if (rvalid) begin
                if (first_rv < 0) first_rv = t;
                if (rready) begin
                    ba  = (burst == 2'b00) ? addr : addr + 32'(4 * beat);
                    bad = m_bad(size, burst, len) || !m_in_range(ba);
                    ed  = bad ? 32'h0 : model[m_idx(ba)];
                    chk($sformatf("%s_b%0d_rdata", tag, beat), rdata, ed);
                    chk($sformatf("%s_b%0d_rresp", tag, beat), 32'(rresp), bad ? 32'd2 : 32'd0);
                    chk($sformatf("%s_b%0d_rlast", tag, beat), 32'(rlast), 32'(beat == len));
                    beat++;
                end else begin
                    stalled = 1'b1; pd = rdata; pl = rlast; pr = rresp;
                end
            end
            if (!aborted) begin
                @(negedge clk); t++;
                if (hs_ar) arvalid = 1'b0;
                if (toggle) rready = ((t % 3) == 2);
            end
        end
        chk({tag, "_rtimeout"}, 32'(t >= 2000), 32'd0);
        if (aborted) begin
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
`ifndef AXI_MEM_STALL_EN
            chk({tag, "_post_arready"}, 32'(arready), 32'd1);
`endif
        end else begin
`ifndef AXI_MEM_STALL_EN
            chk({tag, "_rlatency"}, 32'(first_rv - tar), 32'd2);
            chk({tag, "_idle_arready"}, 32'(arready), 32'd1);
`endif
        end
        rready = 1'b1;
    endtask

    initial begin
        int w, len, r;
        logic [1:0] bu;
        logic [2:0] sz;
        rst_n = 1'b0;
        awvalid = 1'b0; awaddr = 32'h0; awlen = 8'h0; awsize = 3'b010; awburst = 2'b01;
        wvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wlast = 1'b0; bready = 1'b1;
        arvalid = 1'b0; araddr = 32'h0; arlen = 8'h0; arsize = 3'b010; arburst = 2'b01;
        rready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(awready), 32'd1);
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, then byte-lane merge.
        wd_a[0] = 32'hDEADBEEF; ws_a[0] = 4'hF;
        do_write(32'h100, 0, 3'b010, 2'b01, 0, "w_single");
        do_read(32'h100, 0, 3'b010, 2'b01, 1'b0, -1, "r_single");
        wd_a[0] = 32'h0000AB00; ws_a[0] = 4'b0010;
        do_write(32'h100, 0, 3'b010, 2'b01, 0, "w_byte");
        do_read(32'h100, 0, 3'b010, 2'b01, 1'b0, -1, "r_byte");

        // Fill 0x40..0x7C with a 16-beat burst, then read it with rready stalls.
        for (int i = 0; i < 16; i++) begin
            wd_a[i] = $urandom; ws_a[i] = 4'hF;
        end
        do_write(32'h40, 15, 3'b010, 2'b01, 15, "w_fill");
        do_read(32'h40, 15, 3'b010, 2'b01, 1'b1, -1, "r_line");

        // Just past the top of memory; word 0 must stay intact despite aliasing.
        wd_a[0] = 32'h1234_5678; ws_a[0] = 4'hF;
        do_write(32'h0, 0, 3'b010, 2'b01, 0, "w_zero");
        do_read(32'h10000, 0, 3'b010, 2'b01, 1'b0, -1, "r_oor");
        wd_a[0] = 32'hCAFE_F00D; ws_a[0] = 4'hF;
        do_write(32'h10000, 0, 3'b010, 2'b01, 0, "w_oor");
        do_read(32'h0, 0, 3'b010, 2'b01, 1'b0, -1, "r_zero");

        // Over-long burst: 17 beats of SLVERR.
        do_read(32'h40, 16, 3'b010, 2'b01, 1'b0, -1, "r_toolong");

        // Reset during beat 5 of a line read, then a clean read.
        do_read(32'h40, 15, 3'b010, 2'b01, 1'b0, 4, "r_abort");
        do_read(32'h40, 3, 3'b010, 2'b01, 1'b0, -1, "r_after");

        // Early wlast on a two-beat write.
        wd_a[0] = 32'h5A5A_0001; ws_a[0] = 4'hF;
        wd_a[1] = 32'h5A5A_0002; ws_a[1] = 4'hF;
        do_write(32'h200, 1, 3'b010, 2'b01, 0, "w_early");
        do_read(32'h200, 0, 3'b010, 2'b01, 1'b0, -1, "r_early");

        // Randomized traffic inside the initialized line.
        for (int n = 0; n < 24; n++) begin
            w   = $urandom_range(16, 31);
            len = $urandom_range(0, ((31 - w) < 3) ? (31 - w) : 3);
            r   = $urandom_range(0, 7);
            bu  = (r < 2) ? 2'b00 : ((r == 7) ? 2'b10 : 2'b01);
            sz  = ($urandom_range(0, 7) == 0) ? 3'b001 : 3'b010;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin
                    wd_a[i] = $urandom; ws_a[i] = 4'($urandom_range(0, 15));
                end
                do_write(32'(4 * w), len, sz, bu, len, $sformatf("rw%0d", n));
            end else begin
                do_read(32'(4 * w), len, sz, bu, 1'($urandom_range(0, 1)), -1, $sformatf("rr%0d", n));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
